// File: rtl/attn_token_streamer.sv
// rtl/attn_token_streamer.sv - serializes the attention token_out bus into a one-token-per-beat stream
// Define ATTN_STREAM_DROP_CNT_EN to add the saturating drop_count output.
module attn_token_streamer #(
  parameter int DATA_WIDTH   = 16,
  parameter int TOKEN_DIM    = 4,
  parameter int TOKEN_NUM    = 8,
  parameter int PIPE_LATENCY = 4,
  localparam int TOK_W = DATA_WIDTH * TOKEN_DIM,
  localparam int BUS_W = TOK_W * TOKEN_NUM,
  localparam int IDX_W = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  output logic               frame_ready,
  input  logic [BUS_W-1:0]   token_bus,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic [TOK_W-1:0]   tok_data,
  output logic [IDX_W-1:0]   tok_idx,
  output logic               tok_last,
  output logic               frame_drop
`ifdef ATTN_STREAM_DROP_CNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TOKEN_NUM - 1);

  state_t                  state_q, state_d;
  logic [PIPE_LATENCY-1:0] pipe_q, pipe_d;
  logic [BUS_W-1:0]        buf_q, buf_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    drop_q, drop_d;
  logic                    tail, hs, last_hs;

  assign tail = pipe_q[PIPE_LATENCY-1];

  always_comb begin
    pipe_d  = {pipe_q[PIPE_LATENCY-2:0], frame_start};
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    drop_d  = 1'b0;
    hs      = (state_q == STREAM) && tok_ready;
    last_hs = hs && (idx_q == IDX_LAST);
    case (state_q)
      IDLE: begin
        if (tail) begin
          buf_d   = token_bus;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (last_hs) begin
          // A frame arriving on the final beat chains straight on without a bubble.
          idx_d = '0;
          if (tail) buf_d = token_bus;
          else      state_d = IDLE;
        end else begin
          if (hs)   idx_d = idx_q + IDX_W'(1);
          if (tail) drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pipe_q  <= '0;
      buf_q   <= '0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  assign tok_valid   = (state_q == STREAM);
  assign tok_idx     = tok_valid ? idx_q : '0;
  assign tok_data    = tok_valid ? buf_q[idx_q*TOK_W +: TOK_W] : '0;
  assign tok_last    = tok_valid && (idx_q == IDX_LAST);
  assign frame_drop  = drop_q;
  assign frame_ready = (state_q == IDLE) && (pipe_q == '0);

`ifdef ATTN_STREAM_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_attn_token_streamer.sv
// tb/tb_attn_token_streamer.sv - directed self-checking bench for attn_token_streamer
module tb_attn_token_streamer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         frame_start = 1'b0;
  logic         tok_ready = 1'b0;
  logic [511:0] token_bus = '0;
  logic         frame_ready, tok_valid, tok_last, frame_drop;
  logic [63:0]  tok_data;
  logic [2:0]   tok_idx;
`ifdef ATTN_STREAM_DROP_CNT_EN
  logic [15:0]  drop_count;
`endif

  int checks = 0;
  int errors = 0;

  attn_token_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_ready (frame_ready),
    .token_bus   (token_bus),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_data    (tok_data),
    .tok_idx     (tok_idx),
    .tok_last    (tok_last),
    .frame_drop  (frame_drop)
`ifdef ATTN_STREAM_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_tok(input logic [15:0] seed, input logic [15:0] estep, input int t);
    logic [63:0] v;
    for (int e = 0; e < 4; e++) v[e*16 +: 16] = 16'(seed * (t + 1) + estep * e);
    return v;
  endfunction

  function automatic logic [511:0] mk_bus(input logic [15:0] seed, input logic [15:0] estep);
    logic [511:0] b;
    for (int t = 0; t < 8; t++) b[t*64 +: 64] = mk_tok(seed, estep, t);
    return b;
  endfunction

  initial begin
    logic [3:0] pat;
    int cnt;

    // Reset state
    tick;
    tick;
    chk("rst_valid", tok_valid, 0);
    chk("rst_data", tok_data, 0);
    chk("rst_idx", tok_idx, 0);
    chk("rst_last", tok_last, 0);
    chk("rst_drop", frame_drop, 0);
    chk("rst_ready", frame_ready, 1);
    rst_n = 1'b1;
    tick;

    // Single frame, tok_ready held high
    token_bus = mk_bus(16'h0100, 16'h0000);
    tok_ready = 1'b1;
    frame_start = 1'b1;
    chk("t1_ready_idle", frame_ready, 1);
    for (int c = 1; c <= 13; c++) begin
      tick;
      frame_start = 1'b0;
      if (c == 1) chk("t1_ready_busy", frame_ready, 0);
      if (c < 5) chk("t1_pre_valid", tok_valid, 0);
      else if (c <= 12) begin
        chk("t1_valid", tok_valid, 1);
        chk("t1_idx", tok_idx, 64'(c - 5));
        chk("t1_data", tok_data, mk_tok(16'h0100, 16'h0000, c - 5));
        chk("t1_last", tok_last, 64'(c == 12));
        if (c == 5)  chk("t1_first_lit", tok_data, 64'h0100_0100_0100_0100);
        if (c == 12) chk("t1_final_lit", tok_data, 64'h0800_0800_0800_0800);
      end else begin
        chk("t1_post_valid", tok_valid, 0);
        chk("t1_post_ready", frame_ready, 1);
      end
    end
    tick;

    // Backpressure with ready pattern 1,0,0,1
    token_bus = mk_bus(16'h0011, 16'h0001);
    tok_ready = 1'b0;
    frame_start = 1'b1;
    pat = 4'b1001;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick;
      frame_start = 1'b0;
      if (c >= 5) tok_ready = pat[(c - 5) % 4];
      if (tok_valid) begin
        if (cnt < 8) begin
          chk("t2_idx", tok_idx, 64'(cnt));
          chk("t2_data", tok_data, mk_tok(16'h0011, 16'h0001, cnt));
          chk("t2_last", tok_last, 64'(cnt == 7));
        end else chk("t2_extra_beat", tok_valid, 0);
        if (tok_ready) cnt++;
      end
    end
    chk("t2_hs_count", 64'(cnt), 8);
    chk("t2_end_valid", tok_valid, 0);
    tok_ready = 1'b1;
    tick;

    // Back-to-back frames at cycles 0 and 8
    token_bus = mk_bus(16'h0100, 16'h0000);
    frame_start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick;
      frame_start = (c == 8);
      if (c == 5) token_bus = mk_bus(16'h0011, 16'h0001);
      chk("t3_no_drop", frame_drop, 0);
      if (c >= 5 && c <= 20) begin
        chk("t3_valid", tok_valid, 1);
        chk("t3_idx", tok_idx, 64'((c - 5) % 8));
        chk("t3_last", tok_last, 64'(c == 12 || c == 20));
        if (c <= 12) chk("t3_data_a", tok_data, mk_tok(16'h0100, 16'h0000, c - 5));
        else         chk("t3_data_b", tok_data, mk_tok(16'h0011, 16'h0001, c - 13));
      end
      if (c == 21) chk("t3_end_valid", tok_valid, 0);
    end
    tick;

    // Overrun: second frame lands while the first is stalled
    tok_ready = 1'b0;
    token_bus = mk_bus(16'h0100, 16'h0000);
    frame_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick;
      frame_start = (c == 2);
      if (c == 5) token_bus = mk_bus(16'h0011, 16'h0001);
      chk("t4_drop", frame_drop, 64'(c == 7));
      if (c >= 5) begin
        chk("t4_hold_valid", tok_valid, 1);
        chk("t4_hold_idx", tok_idx, 0);
        chk("t4_hold_data", tok_data, mk_tok(16'h0100, 16'h0000, 0));
      end
    end
`ifdef ATTN_STREAM_DROP_CNT_EN
    chk("t4_drop_count", drop_count, 1);
`endif
    tok_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      chk("t4_idx", tok_idx, 64'(b));
      chk("t4_data", tok_data, mk_tok(16'h0100, 16'h0000, b));
      chk("t4_last", tok_last, 64'(b == 7));
      tick;
    end
    chk("t4_end_valid", tok_valid, 0);
    tick;

    // Reset after three handshakes, then a fresh frame
    token_bus = mk_bus(16'h0100, 16'h0000);
    frame_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      frame_start = 1'b0;
    end
    chk("t5_pre_idx", tok_idx, 3);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", tok_valid, 0);
    chk("t5_rst_data", tok_data, 0);
    chk("t5_rst_idx", tok_idx, 0);
    chk("t5_rst_last", tok_last, 0);
    chk("t5_rst_drop", frame_drop, 0);
    chk("t5_rst_ready", frame_ready, 1);
`ifdef ATTN_STREAM_DROP_CNT_EN
    chk("t5_rst_count", drop_count, 0);
`endif
    tick;
    rst_n = 1'b1;
    tick;
    token_bus = mk_bus(16'h0011, 16'h0001);
    frame_start = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick;
      frame_start = 1'b0;
      if (c < 5) chk("t5_pre_valid", tok_valid, 0);
      else if (c <= 12) begin
        chk("t5_idx", tok_idx, 64'(c - 5));
        chk("t5_data", tok_data, mk_tok(16'h0011, 16'h0001, c - 5));
      end else chk("t5_end_valid", tok_valid, 0);
    end

`ifdef ATTN_STREAM_DROP_CNT_EN
    // Saturation: a frame every cycle against a stalled stream
    tok_ready = 1'b0;
    frame_start = 1'b1;
    for (int i = 0; i < 65545; i++) tick;
    chk("t6_drop_pulse", frame_drop, 1);
    chk("t6_saturated", drop_count, 16'hFFFF);
    tick;
    chk("t6_still_sat", drop_count, 16'hFFFF);
    frame_start = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
